i2c_codec_reg_slave: RTL and testbench

I2C_CODEC_REG_SLAVE -- requirements
Module: i2c_codec_reg_slave

---
 rtl/i2c_codec_reg_slave.sv | 236 +++++++++++++++++++++++
 tb/tb_i2c_codec_reg_slave.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_reg_slave.sv
// Write-only I2C target holding a bank of 9-bit codec registers (WM8731-style 7+9 bit framing).
// Optional macro I2C_SLV_SOFT_RESET_EN: a write to register address 7'h0F reloads every register default.
module i2c_codec_reg_slave #(
    parameter logic [6:0] DEVICE_ADDR = 7'h1A,
    parameter int         NUM_REGS    = 10,
    parameter logic [8:0] DEF_R0      = 9'h097,
    parameter logic [8:0] DEF_R1      = 9'h097,
    parameter logic [8:0] DEF_R2      = 9'h079,
    parameter logic [8:0] DEF_R3      = 9'h079,
    parameter logic [8:0] DEF_R4      = 9'h00A,
    parameter logic [8:0] DEF_R5      = 9'h008,
    parameter logic [8:0] DEF_R6      = 9'h09F,
    parameter logic [8:0] DEF_R7      = 9'h00A,
    parameter logic [8:0] DEF_R8      = 9'h000,
    parameter logic [8:0] DEF_R9      = 9'h000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [3:0] rd_addr,
    output logic [8:0] rd_data,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       codec_active,
    output logic       busy,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_ACK_A  = 3'd2,
        ST_BYTE1  = 3'd3,
        ST_ACK_1  = 3'd4,
        ST_BYTE2  = 3'd5,
        ST_ACK_2  = 3'd6,
        ST_IGNORE = 3'd7
    } state_t;

    localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

    function automatic logic [8:0] def_val(input int idx);
        case (idx)
            0:       return DEF_R0;
            1:       return DEF_R1;
            2:       return DEF_R2;
            3:       return DEF_R3;
            4:       return DEF_R4;
            5:       return DEF_R5;
            6:       return DEF_R6;
            7:       return DEF_R7;
            8:       return DEF_R8;
            9:       return DEF_R9;
            default: return 9'h000;
        endcase
    endfunction

    // Synchronizers idle high so a reset release never fakes a START.
    logic r_scl_s1, r_scl_s2, r_scl_h;
    logic r_sda_s1, r_sda_s2, r_sda_h;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_h  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_h  <= 1'b1;
        end else begin
            r_scl_s1 <= scl_in;
            r_scl_s2 <= r_scl_s1;
            r_scl_h  <= r_scl_s2;
            r_sda_s1 <= sda_in;
            r_sda_s2 <= r_sda_s1;
            r_sda_h  <= r_sda_s2;
        end
    end

    logic w_scl_rise, w_scl_fall, w_start, w_stop;

    assign w_scl_rise = r_scl_s2 & ~r_scl_h;
    assign w_scl_fall = ~r_scl_s2 & r_scl_h;
    assign w_start    = r_scl_s2 & r_scl_h & r_sda_h & ~r_sda_s2;
    assign w_stop     = r_scl_s2 & r_scl_h & ~r_sda_h & r_sda_s2;

    state_t     r_state;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [6:0] r_reg_addr;
    logic       r_data_hi;
    logic [7:0] r_data_lo;
    logic       r_sda_oe;
    logic       r_busy;
    logic       r_wr_strobe;
    logic [6:0] r_wr_addr;
    logic [8:0] r_wr_data;
    logic [8:0] r_regs [16];
    logic [8:0] r_rd_data;

    logic       w_reg_in_range;
    logic [8:0] w_wr_word;
    logic       w_addr_match;

    assign w_reg_in_range = ({1'b0, r_reg_addr} < NUM_REGS_W);
    assign w_wr_word      = {r_data_hi, r_data_lo};
    assign w_addr_match   = (r_shift[7:1] == DEVICE_ADDR) && !r_shift[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'd0;
            r_reg_addr  <= 7'd0;
            r_data_hi   <= 1'b0;
            r_data_lo   <= 8'd0;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= 7'd0;
            r_wr_data   <= 9'd0;
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= (i < NUM_REGS) ? def_val(i) : 9'h000;
            end
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_start) begin
                r_state   <= ST_ADDR;
                r_bit_cnt <= 4'd0;
                r_shift   <= 8'd0;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b1;
            end else if (w_stop) begin
                r_state   <= ST_IDLE;
                r_bit_cnt <= 4'd0;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR, ST_BYTE1, ST_BYTE2: begin
                        if (w_scl_rise && (r_bit_cnt < 4'd8)) begin
                            r_shift   <= {r_shift[6:0], r_sda_s2};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                            // Falling edge after the 8th bit: decide whether to drive the ACK slot.
                            r_bit_cnt <= 4'd0;
                            case (r_state)
                                ST_ADDR: begin
                                    if (w_addr_match) begin
                                        r_state  <= ST_ACK_A;
                                        r_sda_oe <= 1'b1;
                                    end else begin
                                        r_state  <= ST_IGNORE;
                                    end
                                end
                                ST_BYTE1: begin
                                    r_reg_addr <= r_shift[7:1];
                                    r_data_hi  <= r_shift[0];
                                    r_state    <= ST_ACK_1;
                                    r_sda_oe   <= 1'b1;
                                end
                                default: begin
                                    r_data_lo <= r_shift;
                                    r_state   <= ST_ACK_2;
                                    r_sda_oe  <= 1'b1;
                                end
                            endcase
                        end
                    end
                    ST_ACK_A: begin
                        if (w_scl_fall) begin
                            r_sda_oe <= 1'b0;
                            r_state  <= ST_BYTE1;
                        end
                    end
                    ST_ACK_1: begin
                        if (w_scl_fall) begin
                            r_sda_oe <= 1'b0;
                            r_state  <= ST_BYTE2;
                        end
                    end
                    ST_ACK_2: begin
                        if (w_scl_fall) begin
                            r_sda_oe  <= 1'b0;
                            r_state   <= ST_BYTE1;
                            r_wr_addr <= r_reg_addr;
                            r_wr_data <= w_wr_word;
`ifdef I2C_SLV_SOFT_RESET_EN
                            if (r_reg_addr == 7'h0F) begin
                                for (int i = 0; i < 16; i++) begin
                                    r_regs[i] <= (i < NUM_REGS) ? def_val(i) : 9'h000;
                                end
                                r_wr_strobe <= 1'b1;
                            end else if (w_reg_in_range) begin
                                r_regs[r_reg_addr[3:0]] <= w_wr_word;
                                r_wr_strobe             <= 1'b1;
                            end
`else
                            if (w_reg_in_range) begin
                                r_regs[r_reg_addr[3:0]] <= w_wr_word;
                                r_wr_strobe             <= 1'b1;
                            end
`endif
                        end
                    end
                    default: begin
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= 9'h000;
        end else if ({4'd0, rd_addr} < NUM_REGS_W) begin
            r_rd_data <= r_regs[rd_addr];
        end else begin
            r_rd_data <= 9'h000;
        end
    end

    assign sda_oe       = r_sda_oe;
    assign busy         = r_busy;
    assign wr_strobe    = r_wr_strobe;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign rd_data      = r_rd_data;
    assign codec_active = r_regs[9][0];
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_i2c_codec_reg_slave.sv
// Bench for i2c_codec_reg_slave: bit-banged I2C master, register-bank reference model and
// write scoreboard; directed scenarios followed by randomized transactions.
module tb_i2c_codec_reg_slave;

  localparam int H = 6;  // SCL half-period in clk cycles

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [3:0] rd_addr = 4'd0;
  logic       sda_oe;
  logic [8:0] rd_data;
  logic       wr_strobe;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic       codec_active;
  logic       busy;
  logic [2:0] dbg_state;
  wire        sda_bus = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_codec_reg_slave dut (
    .clk          (clk),
    .reset        (reset),
    .scl_in       (m_scl),
    .sda_in       (sda_bus),
    .sda_oe       (sda_oe),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .codec_active (codec_active),
    .busy         (busy),
    .o_dbg_state  (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0]  defs [10] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                             9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
  logic [8:0]  m_regs [16];
  logic [6:0]  last_wa;
  logic [8:0]  last_wd;
  logic [15:0] exp_q[$];
  logic [7:0]  tx_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every accepted write must match the oldest predicted write.
  always @(negedge clk) begin
    if (!reset && wr_strobe) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {16'd0, wr_addr, wr_data}, 32'd0);
      end else begin
        check("strobe_addr_data", {16'd0, wr_addr, wr_data}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = (i < 10) ? defs[i] : 9'h000;
    last_wa = 7'd0;
    last_wd = 9'd0;
  endtask

  task automatic model_write(input logic [7:0] b1, input logic [7:0] b2);
    logic [6:0] a;
    logic [8:0] d;
    a = b1[7:1];
    d = {b1[0], b2};
    last_wa = a;
    last_wd = d;
`ifdef I2C_SLV_SOFT_RESET_EN
    if (a == 7'h0F) begin
      for (int i = 0; i < 10; i++) m_regs[i] = defs[i];
      exp_q.push_back({a, d});
    end else if (a < 7'd10) begin
      m_regs[a[3:0]] = d;
      exp_q.push_back({a, d});
    end
`else
    if (a < 7'd10) begin
      m_regs[a[3:0]] = d;
      exp_q.push_back({a, d});
    end
`endif
  endtask

  task automatic send_start();
    wait_clk(2);
    m_sda = 1'b1;
    wait_clk(H);
    m_scl = 1'b1;
    wait_clk(H);
    m_sda = 1'b0;
    wait_clk(H);
    m_scl = 1'b0;
  endtask

  task automatic send_stop();
    wait_clk(2);
    m_sda = 1'b0;
    wait_clk(H);
    m_scl = 1'b1;
    wait_clk(H);
    m_sda = 1'b1;
    wait_clk(H);
  endtask

  task automatic send_bit(input logic b);
    wait_clk(2);
    m_sda = b;
    wait_clk(H);
    m_scl = 1'b1;
    wait_clk(H);
    m_scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    wait_clk(2);
    m_sda = 1'b1;
    wait_clk(H);
    m_scl = 1'b1;
    wait_clk(H / 2);
    ack = ~sda_bus;
    wait_clk(H - H / 2);
    m_scl = 1'b0;
  endtask

  task automatic check_regs();
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      wait_clk(1);
      check($sformatf("rd_data[%0d]", i), {23'd0, rd_data}, {23'd0, m_regs[i]});
    end
    check("codec_active", {31'd0, codec_active}, {31'd0, m_regs[9][0]});
  endtask

  // Drives tx_q as one transaction; partial_bits extra bits are clocked after the full bytes.
  task automatic run_txn(input int partial_bits, input bit end_stop);
    logic       ack;
    logic       exp_ack;
    logic       matched;
    logic [7:0] b1;
    matched = 1'b0;
    b1 = 8'h00;
    send_start();
    check("busy_after_start", {31'd0, busy}, 32'd1);
    for (int i = 0; i < tx_q.size(); i++) begin
      if (i == 0) begin
        matched = (tx_q[0] == 8'h34);
        exp_ack = matched;
      end else begin
        exp_ack = matched;
        if (matched && (i % 2 == 1)) b1 = tx_q[i];
        if (matched && (i % 2 == 0)) model_write(b1, tx_q[i]);
      end
      send_byte(tx_q[i], ack);
      check($sformatf("ack_byte%0d", i), {31'd0, ack}, {31'd0, exp_ack});
    end
    for (int i = 0; i < partial_bits; i++) send_bit(1'($urandom_range(0, 1)));
    if (end_stop) begin
      send_stop();
      check("busy_after_stop", {31'd0, busy}, 32'd0);
      check("sda_oe_idle", {31'd0, sda_oe}, 32'd0);
    end
    wait_clk(4);
    check("pending_writes", exp_q.size(), 32'd0);
    check("wr_addr_last", {25'd0, wr_addr}, {25'd0, last_wa});
    check("wr_data_last", {23'd0, wr_data}, {23'd0, last_wd});
    check_regs();
  endtask

  initial begin
    logic ack;
    int   n;
    model_reset();
    wait_clk(3);
    reset = 1'b0;
    wait_clk(1);
    check("rst_rd_data0", {23'd0, rd_data}, {23'd0, defs[0]});
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_addr", {25'd0, wr_addr}, 32'd0);
    check("rst_wr_data", {23'd0, wr_data}, 32'd0);
    check_regs();

    // Single write to R9 sets codec_active.
    tx_q = '{8'h34, 8'h12, 8'h01};
    run_txn(0, 1'b1);
    check("codec_active_set", {31'd0, codec_active}, 32'd1);

    // Wrong address and read direction are ignored.
    tx_q = '{8'h36, 8'h12, 8'h01};
    run_txn(0, 1'b1);
    tx_q = '{8'h35, 8'h12, 8'h01};
    run_txn(0, 1'b1);

    // Back-to-back writes to R4 and R5.
    tx_q = '{8'h34, 8'h08, 8'h7B, 8'h0B, 8'h7B};
    run_txn(0, 1'b1);

    // STOP five bits into the data byte, then a normal write to R0.
    tx_q = '{8'h34, 8'h00};
    run_txn(5, 1'b1);
    tx_q = '{8'h34, 8'h00, 8'h55};
    run_txn(0, 1'b1);

    // R0 = 1FF, then a write to address 0x0F.
    tx_q = '{8'h34, 8'h01, 8'hFF};
    run_txn(0, 1'b1);
    tx_q = '{8'h34, 8'h1E, 8'h00};
    run_txn(0, 1'b1);

    // Repeated START after BYTE1 discards the half-written pair.
    tx_q = '{8'h34, 8'h02};
    run_txn(0, 1'b0);
    tx_q = '{8'h34, 8'h0E, 8'h0A};
    run_txn(0, 1'b1);

    // Reset while the address ACK is being driven.
    send_start();
    for (int i = 7; i >= 0; i--) send_bit(n_tests >= 0 ? 1'(8'h34 >> i) : 1'b0);
    wait_clk(5);
    check("ack_before_reset", {31'd0, sda_oe}, 32'd1);
    reset = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    model_reset();
    wait_clk(1);
    check("sda_oe_after_reset", {31'd0, sda_oe}, 32'd0);
    check("busy_after_reset", {31'd0, busy}, 32'd0);
    send_bit(1'b1);
    send_byte(8'h00, ack);
    check("no_ack_after_reset", {31'd0, ack}, 32'd0);
    send_byte(8'h00, ack);
    check("no_ack_after_reset2", {31'd0, ack}, 32'd0);
    send_stop();
    wait_clk(4);
    check("pending_after_reset", exp_q.size(), 32'd0);
    check_regs();

    // Randomized transactions.
    for (int t = 0; t < 24; t++) begin
      tx_q.delete();
      tx_q.push_back(($urandom_range(0, 9) < 8) ? 8'h34 : 8'($urandom_range(0, 255)));
      n = $urandom_range(0, 5);
      for (int k = 0; k < n; k++) begin
        if (k % 2 == 0) tx_q.push_back({7'($urandom_range(0, 20)), 1'($urandom_range(0, 1))});
        else tx_q.push_back(8'($urandom_range(0, 255)));
      end
      run_txn(($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0,
              ($urandom_range(0, 4) != 0));
    end
    send_stop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
